// File: rtl/straits_sequencer.sv
// straits_sequencer: control-word generator for the dire_straits enable decoder.
// After a start request it plays a programmable number of rounds. Each round is
// one CLR cycle followed by one SEL cycle, and the AND pattern rotates left once
// between rounds. hold freezes the whole block.
// Optional feature: define STRAITS_PARITY_EN to add par_out, a registered even
// parity over {A_out, B_out, AND_out}.
module straits_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] lane_mask,
    input  logic [WIDTH-1:0] and_pattern,
    input  logic [CNT_W-1:0] rounds,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic [WIDTH-1:0] AND_out,
    output logic             busy,
    output logic             done,
`ifdef STRAITS_PARITY_EN
    output logic             par_out,
`endif
    output logic [CNT_W-1:0] round_cnt
);

    typedef enum logic [1:0] {IDLE, CLR, SEL, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mask_q, mask_nxt;
    logic [WIDTH-1:0] pat_q, pat_nxt;
    logic [CNT_W-1:0] rounds_q, rounds_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt, and_nxt;
    logic             busy_nxt, done_nxt;

    // Next-state, capture and round-counting rules.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt  = state;
        mask_nxt   = mask_q;
        pat_nxt    = pat_q;
        rounds_nxt = rounds_q;
        cnt_nxt    = round_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt = '0;
                    if (rounds != '0) begin
                        mask_nxt   = lane_mask;
                        pat_nxt    = and_pattern;
                        rounds_nxt = rounds;
                        state_nxt  = CLR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CLR: state_nxt = SEL;
            SEL: begin
                // rounds_q is never 0 here, so round_cnt + 1 cannot exceed it: no wrap.
                cnt_nxt = round_cnt + CNT_W'(1);
                if (cnt_nxt == rounds_q) begin
                    state_nxt = DONE;
                end else begin
                    pat_nxt   = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                    state_nxt = CLR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values for the state being entered, so the registered outputs track the state.
    always_comb begin
        a_nxt    = '0;
        b_nxt    = '0;
        and_nxt  = '0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            CLR: begin
                b_nxt    = '1;
                and_nxt  = pat_nxt;
                busy_nxt = 1'b1;
            end
            SEL: begin
                a_nxt    = mask_nxt;
                b_nxt    = '1;
                and_nxt  = pat_nxt;
                busy_nxt = 1'b1;
            end
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, captured operands and registered outputs; hold freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            mask_q    <= '0;
            pat_q     <= '0;
            rounds_q  <= '0;
            round_cnt <= '0;
            A_out     <= '0;
            B_out     <= '0;
            AND_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef STRAITS_PARITY_EN
            par_out   <= 1'b0;
`endif
        end else if (!hold) begin
            state     <= state_nxt;
            mask_q    <= mask_nxt;
            pat_q     <= pat_nxt;
            rounds_q  <= rounds_nxt;
            round_cnt <= cnt_nxt;
            A_out     <= a_nxt;
            B_out     <= b_nxt;
            AND_out   <= and_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
`ifdef STRAITS_PARITY_EN
            par_out   <= ^{a_nxt, b_nxt, and_nxt};
`endif
        end
    end

endmodule
